vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised display timing and sync generator, the next generation of the fixed 1024x768 generator. It produces the horizontal and vertical sync, blanking, pixel coordinates and frame bookkeeping for any VESA-style mode chosen at elaboration. It adds a pixel-clock enable, line/frame strobes, a frame counter and an optional look-ahead fetch address for pipelined pixel memories. It sits between the pixel-clock domain and the video/colour mapper.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 144, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, horizontal sync asserted level (0 = active-low)
- VS_POL, 0, vertical sync asserted level
- CNT_W, 12, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- LOOKAHEAD, 2, fetch lead in pixel ticks, 1..H_TOTAL-1 (used only with DTG_LOOKAHEAD_EN)
- clock  in  1  pixel-domain clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; the timing advances only on cycles where pix_en=1
- horiz_sync  out  1  horizontal sync, polarity per HS_POL
- vert_sync  out  1  vertical sync, polarity per VS_POL
- video_on  out  1  1 when the current pixel is in the active area
- pixel_column  out  CNT_W  current column, 0..H_TOTAL-1
- pixel_row  out  CNT_W  current row, 0..V_TOTAL-1
- line_start  out  1  one-clock pulse when pixel_column becomes 0
- frame_start  out  1  one-clock pulse when the position becomes (0,0)
- frame_count  out  8  number of completed frames, modulo 256
- fetch_column, fetch_row  out  CNT_W  look-ahead coordinates (DTG_LOOKAHEAD_EN only)
- fetch_valid  out  1  look-ahead position is in the active area (DTG_LOOKAHEAD_EN only)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1328). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- Internal counters h_cnt and v_cnt. h_cnt increments on each pix_en and wraps from H_TOTAL-1 to 0. v_cnt increments when h_cnt wraps and itself wraps from V_TOTAL-1 to 0.
- Every output is a single register stage decoded from the counters, so all outputs are mutually aligned and describe the same pixel.
- horiz_sync is at level HS_POL when column is in H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1, otherwise ~HS_POL. vert_sync is decoded the same way from rows with V_* and VS_POL.
- video_on = (column < H_ACTIVE) && (row < V_ACTIVE).
- frame_count increments on the tick that loads (0,0), excluding the first tick after reset. It wraps from 255 to 0.
- No state machine beyond the counters. The "phases" (active, front porch, sync, back porch) are pure decodes of the counters.

## Timing
- Reset values: pixel_column=0, pixel_row=0, video_on=0, horiz_sync=~HS_POL, vert_sync=~VS_POL, line_start=0, frame_start=0, frame_count=0, fetch_*=0, fetch_valid=0.
- The first pix_en after reset release presents (0,0): video_on=1, line_start=1, frame_start=1.
- Outputs update only on clocks with pix_en=1 and hold otherwise.
- line_start and frame_start are high for exactly one clock, the clock following the pix_en tick that loaded column 0. They are low on every other clock, including held cycles.
- rst asserted mid-frame overrides pix_en and restores all reset values on the next edge.

## Configuration
- DTG_LOOKAHEAD_EN defined: a second counter pair runs LOOKAHEAD ticks ahead of the main position, with the same wrap rules across line and frame boundaries.
  - fetch_column/fetch_row equal the coordinates pixel_column/pixel_row will hold LOOKAHEAD ticks later.
  - fetch_valid is the active-area decode of that look-ahead position.
  - After the first tick post-reset: fetch = (LOOKAHEAD, 0).
- DTG_LOOKAHEAD_EN undefined: fetch_column, fetch_row and fetch_valid ports and their logic are absent.

## Test plan
- Defaults with pix_en=1 continuously: line period is 1328 clocks; horiz_sync is low for columns 1048..1183 (136 clocks); video_on is high for columns 0..1023 on rows 0..767 only.
- Full frame with defaults: vert_sync is low for rows 771..776; frame_start pulses every 1328*806 = 1070368 clocks; frame_count reads 1 after the second frame_start.
- pix_en toggling 1,0,1,0: the line period doubles to 2656 clocks, outputs hold on pix_en=0 cycles, and line_start is a single-clock pulse.
- HS_POL=1, VS_POL=1, 640x480 mode (16/96/48, 10/2/33): H_TOTAL=800 and V_TOTAL=525; syncs are high for columns 656..751 and rows 490..491.
- Assert rst at row 400, column 500: the next edge gives all reset values; the first subsequent pix_en gives (0,0) with frame_start=1.
- DTG_LOOKAHEAD_EN, LOOKAHEAD=2: at pixel_column=1326, row 767, fetch=(0,768) and fetch_valid=0. At row 805, column 1327, fetch=(1,0) and fetch_valid=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VESA-style display timing / sync generator.
//
// Produces horizontal/vertical sync, active-area flag, pixel coordinates,
// line/frame start strobes and a completed-frame counter. Timing advances
// only on clocks with pix_en_i=1; all outputs are one register stage
// decoded from the position counters, so they describe the same pixel.
//
// Optional feature (macro DTG_LOOKAHEAD_EN): a second counter pair running
// LOOKAHEAD ticks ahead, exported as fetch_column_o/fetch_row_o/fetch_valid_o
// for pipelined pixel memories.
//
// Ports:
//   clock           pixel-domain clock
//   rst             synchronous active-high reset
//   pix_en_i        pixel tick
//   horiz_sync_o    horizontal sync (asserted level HS_POL)
//   vert_sync_o     vertical sync (asserted level VS_POL)
//   video_on_o      current pixel is in the active area
//   pixel_column_o  current column 0..H_TOTAL-1
//   pixel_row_o     current row 0..V_TOTAL-1
//   line_start_o    one-clock pulse when column 0 is presented
//   frame_start_o   one-clock pulse when (0,0) is presented
//   frame_count_o   completed frames modulo 256
//   fetch_*_o       look-ahead position and its active flag (DTG_LOOKAHEAD_EN)
module vga_timing_gen #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 144,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 12,
    parameter int LOOKAHEAD = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             pix_en_i,
    output logic             horiz_sync_o,
    output logic             vert_sync_o,
    output logic             video_on_o,
    output logic [CNT_W-1:0] pixel_column_o,
    output logic [CNT_W-1:0] pixel_row_o,
    output logic             line_start_o,
    output logic             frame_start_o,
`ifdef DTG_LOOKAHEAD_EN
    output logic [CNT_W-1:0] fetch_column_o,
    output logic [CNT_W-1:0] fetch_row_o,
    output logic             fetch_valid_o,
`endif
    output logic [7:0]       frame_count_o
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_BEG  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_BEG  = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    // Shared raster advance: one tick forward with line/frame wrap.
    function automatic cnt_t next_h(input cnt_t h);
        return (h == H_LAST) ? '0 : h + cnt_t'(1);
    endfunction

    function automatic cnt_t next_v(input cnt_t h, input cnt_t v);
        if (h != H_LAST) return v;
        return (v == V_LAST) ? '0 : v + cnt_t'(1);
    endfunction

    // h_cnt_q/v_cnt_q hold the position the NEXT tick will present, so the
    // first tick after reset presents (0,0) with no special casing.
    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;
    logic started_q;  // distinguishes the initial (0,0) from a real frame wrap

    logic       hs_q, vs_q, von_q, ls_q, fs_q;
    cnt_t       col_q, row_q;
    logic [7:0] fcnt_q;

    logic at_origin;

    always_comb begin
        h_cnt_d   = next_h(h_cnt_q);
        v_cnt_d   = next_v(h_cnt_q, v_cnt_q);
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            started_q <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            von_q     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            // Strobes are single-clock: cleared on every non-loading clock.
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            if (pix_en_i) begin
                h_cnt_q   <= h_cnt_d;
                v_cnt_q   <= v_cnt_d;
                started_q <= 1'b1;
                col_q     <= h_cnt_q;
                row_q     <= v_cnt_q;
                von_q     <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
                hs_q      <= ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
                vs_q      <= ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
                ls_q      <= (h_cnt_q == '0);
                fs_q      <= at_origin;
                if (at_origin && started_q)
                    fcnt_q <= fcnt_q + 8'd1;
            end
        end
    end

    assign horiz_sync_o   = hs_q;
    assign vert_sync_o    = vs_q;
    assign video_on_o     = von_q;
    assign pixel_column_o = col_q;
    assign pixel_row_o    = row_q;
    assign line_start_o   = ls_q;
    assign frame_start_o  = fs_q;
    assign frame_count_o  = fcnt_q;

`ifdef DTG_LOOKAHEAD_EN
    // Look-ahead pair starts LOOKAHEAD pixels into row 0 (LOOKAHEAD < H_TOTAL)
    // and advances in lock-step with the main counters.
    localparam cnt_t LA_C = cnt_t'(LOOKAHEAD);

    cnt_t fh_cnt_q, fv_cnt_q;
    cnt_t fcol_q, frow_q;
    logic fval_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            fh_cnt_q <= LA_C;
            fv_cnt_q <= '0;
            fcol_q   <= '0;
            frow_q   <= '0;
            fval_q   <= 1'b0;
        end else if (pix_en_i) begin
            fh_cnt_q <= next_h(fh_cnt_q);
            fv_cnt_q <= next_v(fh_cnt_q, fv_cnt_q);
            fcol_q   <= fh_cnt_q;
            frow_q   <= fv_cnt_q;
            fval_q   <= (fh_cnt_q < H_ACT) && (fv_cnt_q < V_ACT);
        end
    end

    assign fetch_column_o = fcol_q;
    assign fetch_row_o    = frow_q;
    assign fetch_valid_o  = fval_q;
`endif

endmodule
